// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: captures one received frame into a byte store, tags it with
// length / partial-byte / error / overflow status, and plays it back to a
// consumer on request. Frames lost to errors or pre-emption are counted.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | no frame held, waiting for start of frame
// S_RECEIVING | storing bytes, accumulating error / overflow status
// S_READY     | complete frame held, consumer may read and release it
module rx_frame_buffer #(
   parameter int DEPTH         = 16,
   parameter int DROP_ON_ERROR = 1,
   parameter int DROP_CNT_W    = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         rx_soc,
   input  logic                         rx_eoc,
   input  logic [7:0]                   rx_data,
   input  logic [2:0]                   rx_data_bits,
   input  logic                         rx_data_valid,
   input  logic                         rx_sequence_error,
   input  logic                         rx_parity_error,
   input  logic                         rd_req,
   input  logic                         frame_release,
   output logic                         frame_ready,
   output logic [$clog2(DEPTH+1)-1:0]   frame_len,
   output logic [2:0]                   frame_last_bits,
   output logic                         frame_error,
   output logic                         overflow,
   output logic [7:0]                   rd_data,
   output logic                         rd_valid,
   output logic [DROP_CNT_W-1:0]        drop_cnt
);

   localparam int LEN_W  = $clog2(DEPTH + 1);
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RECEIVING = 2'd1,
      S_READY     = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [LEN_W-1:0]      count_q, count_d;
   logic [LEN_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [2:0]            last_bits_q, last_bits_d;
   logic                  error_q, error_d;
   logic                  overflow_q, overflow_d;
   logic [7:0]            rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [7:0]            mem_q [DEPTH];

   logic             restart_rx;
   logic             rx_active;
   logic             wr_en;
   logic             rx_ovf;
   logic             rx_err;
   logic             err_after;
   logic [LEN_W-1:0] len_after;
   logic             eoc_take;
   logic             ready_soc;
   logic             clear_frame;
   logic             rd_fire;
   logic             drop_inc;

   // Per-cycle events; eoc wins over a coincident soc while receiving, and a
   // byte arriving with eoc is counted before the end-of-frame decision.
   always_comb begin
      restart_rx  = (state_q == S_RECEIVING) && rx_soc && !rx_eoc;
      rx_active   = (state_q == S_RECEIVING) && !restart_rx;
      wr_en       = rx_active && rx_data_valid && (count_q < DEPTH_L);
      rx_ovf      = rx_active && rx_data_valid && (count_q >= DEPTH_L);
      rx_err      = rx_active && ((rx_data_valid && (last_bits_q != 3'd0)) ||
                                  rx_ovf || rx_parity_error || rx_sequence_error);
      err_after   = error_q || rx_err;
      len_after   = wr_en ? count_q + LEN_W'(1) : count_q;
      eoc_take    = (state_q == S_RECEIVING) && rx_eoc;
      ready_soc   = (state_q == S_READY) && rx_soc;
      clear_frame = ((state_q == S_IDLE) && rx_soc) || restart_rx || ready_soc;
      rd_fire     = (state_q == S_READY) && !rx_soc && rd_req && (rd_ptr_q < count_q);
      drop_inc    = ready_soc ||
                    (eoc_take && (len_after != '0) && err_after && (DROP_ON_ERROR != 0));
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decision
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (rx_soc) state_d = S_RECEIVING;
         end
         S_RECEIVING: begin
            if (eoc_take) begin
               if (len_after == '0)                         state_d = S_IDLE;
               else if (err_after && (DROP_ON_ERROR != 0))  state_d = S_IDLE;
               else                                         state_d = S_READY;
            end
         end
         S_READY: begin
            if (rx_soc)             state_d = S_RECEIVING;
            else if (frame_release) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: frame status is only presented while a frame is held
   always_comb begin
      frame_ready     = (state_q == S_READY);
      frame_len       = frame_ready ? count_q : '0;
      frame_last_bits = frame_ready ? last_bits_q : 3'd0;
      frame_error     = frame_ready && error_q;
      overflow        = frame_ready && overflow_q;
      rd_data         = rd_data_q;
      rd_valid        = rd_valid_q;
      drop_cnt        = drop_cnt_q;
   end

   // Datapath next values: frame bookkeeping, readback and drop counting
   always_comb begin
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      last_bits_d = last_bits_q;
      error_d     = error_q;
      overflow_d  = overflow_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      drop_cnt_d  = drop_cnt_q;

      if (clear_frame) begin
         count_d     = '0;
         rd_ptr_d    = '0;
         last_bits_d = 3'd0;
         error_d     = 1'b0;
         overflow_d  = 1'b0;
      end else begin
         if (wr_en) begin
            count_d     = len_after;
            last_bits_d = rx_data_bits;
         end
         if (rx_ovf) overflow_d = 1'b1;
         if (rx_err) error_d    = 1'b1;
      end

      if (rd_fire) begin
         rd_ptr_d   = rd_ptr_q + LEN_W'(1);
         rd_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
         rd_valid_d = 1'b1;
      end

      if (drop_inc && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= '0;
         rd_ptr_q    <= '0;
         last_bits_q <= 3'd0;
         error_q     <= 1'b0;
         overflow_q  <= 1'b0;
         rd_data_q   <= 8'd0;
         rd_valid_q  <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         last_bits_q <= last_bits_d;
         error_q     <= error_d;
         overflow_q  <= overflow_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Byte store; the write address is the running byte count
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[count_q[ADDR_W-1:0]] <= rx_data;
   end

endmodule

// File: doc/rx_frame_buffer.md
RX_FRAME_BUFFER -- requirements
Module: rx_frame_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, byte capacity of one frame (power of two, >= 2).
REQ-002 SHALL have parameter DROP_ON_ERROR, default 1, where 1 discards errored frames and 0 delivers them flagged.
REQ-003 SHALL have parameter DROP_CNT_W, default 4, width of the dropped-frame counter.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk  in  1  13.56MHz recovered carrier clock.
REQ-006 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have port rx_soc  in  1  start of frame strobe.
REQ-008 SHALL have port rx_eoc  in  1  end of frame strobe.
REQ-009 SHALL have port rx_data  in  8  received byte, LSB first.
REQ-010 SHALL have port rx_data_bits  in  3  valid bits in rx_data; 0 means 8.
REQ-011 SHALL have port rx_data_valid  in  1  rx_data strobe.
REQ-012 SHALL have port rx_sequence_error  in  1  sequence error strobe.
REQ-013 SHALL have port rx_parity_error  in  1  parity error strobe.
REQ-014 SHALL have port rd_req  in  1  consumer byte read request.
REQ-015 SHALL have port frame_release  in  1  consumer done with frame.
REQ-016 SHALL have port frame_ready  out  1  complete frame held.
REQ-017 SHALL have port frame_len  out  $clog2(DEPTH+1)  stored byte count, partial byte included.
REQ-018 SHALL have port frame_last_bits  out  3  valid bits of last byte; 0 means 8.
REQ-019 SHALL have port frame_error  out  1  held frame contains an error.
REQ-020 SHALL have port overflow  out  1  held frame exceeded DEPTH.
REQ-021 SHALL have port rd_data  out  8  read byte.
REQ-022 SHALL have port rd_valid  out  1  rd_data strobe.
REQ-023 SHALL have port drop_cnt  out  DROP_CNT_W  saturating count of frames lost.

Function
REQ-024 SHALL implement states IDLE, RECEIVING, READY.
REQ-025 IDLE: on rx_soc -> RECEIVING, clearing wr_ptr, rd_ptr, last_bits, error, overflow.
REQ-026 RECEIVING: on rx_data_valid with count < DEPTH, store rx_data at mem[wr_ptr], increment count, and latch rx_data_bits into last_bits.
REQ-027 RECEIVING: a byte arriving after a partial byte (last_bits != 0) SHALL set error; the byte is still stored if space remains.
REQ-028 RECEIVING: on rx_data_valid with count == DEPTH, the byte is not stored, and overflow and error set (sticky until next soc).
REQ-029 RECEIVING: rx_parity_error or rx_sequence_error sets error.
REQ-030 RECEIVING + rx_eoc: count == 0 -> IDLE silently; error && DROP_ON_ERROR -> IDLE, drop_cnt+1; else -> READY.
REQ-031 RECEIVING + rx_soc (without eoc) SHALL restart: pointers and flags clear and the state stays RECEIVING.
REQ-032 rx_data_valid coincident with rx_eoc SHALL process the byte first; the byte is included in the frame.
REQ-033 rx_soc coincident with rx_eoc in RECEIVING SHALL take the eoc, and the soc is ignored.
REQ-034 READY: frame_ready=1; frame_len, frame_last_bits, frame_error and overflow are stable.
REQ-035 READY: rd_req with rd_ptr < count -> next cycle rd_valid=1 for one cycle, rd_data=mem[rd_ptr], rd_ptr+1; 1-cycle latency, back-to-back reads allowed.
REQ-036 READY: rd_req with rd_ptr == count SHALL be ignored (no rd_valid).
REQ-037 rd_req outside READY SHALL be ignored.
REQ-038 READY + frame_release -> IDLE, frame_ready low next cycle; an in-flight rd_valid still completes.
REQ-039 READY + rx_soc SHALL discard the held frame, increment drop_cnt, and enter RECEIVING; soc takes priority over a coincident frame_release.
REQ-040 drop_cnt SHALL saturate at 2^DROP_CNT_W-1 and never wrap.
REQ-041 rx_eoc, rx_data_valid and errors in IDLE SHALL be ignored.
REQ-042 The memory is plain registers; no reset of mem contents is required.

Reset
REQ-043 rst SHALL asynchronously force IDLE and set all outputs, pointers, counters and flags to 0.
REQ-044 Reset mid-RECEIVING or mid-READY SHALL lose the frame without incrementing drop_cnt.

Verification
REQ-045 Scenario 1: soc, bytes 0x93,0x20, eoc; then 2 rd_req -> frame_len=2, last_bits=0, rd_data 0x93 then 0x20, one cycle after each req.
REQ-046 Scenario 2: soc, 0x26 with data_bits=7, eoc -> frame_len=1, frame_last_bits=7, frame_error=0.
REQ-047 Scenario 3 (DEPTH=16): soc, 17 bytes, eoc, DROP_ON_ERROR=0 -> frame_len=16, overflow=1, frame_error=1; with DROP_ON_ERROR=1 -> stays IDLE, drop_cnt=1.
REQ-048 Scenario 4: parity_error mid-frame, DROP_ON_ERROR=1 -> frame_ready never asserts, drop_cnt=1; a new frame in READY + soc -> drop_cnt=2.
REQ-049 Scenario 5: in READY read all bytes, one extra rd_req -> no rd_valid; frame_release -> IDLE; drop_cnt driven past 15 -> holds 15.
REQ-050 Scenario 6: rst pulse mid-frame -> all outputs 0 immediately; next soc/byte/eoc frame delivered normally.
